// File: rtl/matrix_stream_ctrl.sv
// matrix_stream_ctrl
//   Streaming controller for a 2x2 fixed-point matrix-vector datapath
//   (Y = M1*A + M2*B, Z = M3*A + M4*B). Holds the four coefficient
//   registers, launches (A,B) samples into a fixed-latency, non-stallable
//   datapath, tags in-flight samples and captures the results into an
//   output FIFO. Input acceptance is credit based: a sample is accepted
//   only when a FIFO slot is guaranteed for it, so backpressure on the
//   output never has to stall the datapath.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data coefficient write (0=M1 1=M2 2=M3 3=M4)
//   cfg_err                  one-cycle pulse: write rejected (pipeline busy)
//   s_valid/s_ready/s_a/s_b  sample input handshake
//   dp_vld/dp_a/dp_b         registered launch to datapath
//   dp_m1..dp_m4             coefficient registers to datapath
//   dp_y/dp_z                datapath results (valid LATENCY cycles after dp_vld)
//   m_valid/m_ready/m_y/m_z  result output handshake (FIFO head)
//   inflight                 samples launched but not yet captured
module matrix_stream_ctrl #(
  parameter int LATENCY    = 5,
  parameter int FIFO_DEPTH = 8,
  parameter int IN_W       = 13,
  parameter int OUT_W      = 17,
  parameter int COEF_W     = 19
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_we,
  input  logic [1:0]                     cfg_addr,
  input  logic [COEF_W-1:0]              cfg_data,
  output logic                           cfg_err,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [IN_W-1:0]                s_a,
  input  logic [IN_W-1:0]                s_b,
  output logic                           dp_vld,
  output logic [IN_W-1:0]                dp_a,
  output logic [IN_W-1:0]                dp_b,
  output logic [COEF_W-1:0]              dp_m1,
  output logic [COEF_W-1:0]              dp_m2,
  output logic [COEF_W-1:0]              dp_m3,
  output logic [COEF_W-1:0]              dp_m4,
  input  logic [OUT_W-1:0]               dp_y,
  input  logic [OUT_W-1:0]               dp_z,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [OUT_W-1:0]               m_y,
  output logic [OUT_W-1:0]               m_z,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int INF_W = $clog2(LATENCY + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // One extra bit so inflight + fifo_count can never wrap.
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  localparam logic [COEF_W-1:0] M1_RST = COEF_W'(19'h7F8F6);
  localparam logic [COEF_W-1:0] M2_RST = COEF_W'(19'h09333);
  localparam logic [COEF_W-1:0] M3_RST = COEF_W'(19'h0C8F6);
  localparam logic [COEF_W-1:0] M4_RST = COEF_W'(19'h53000);

  logic [LATENCY-1:0] tag;
  logic [OUT_W-1:0]   mem_y [FIFO_DEPTH];
  logic [OUT_W-1:0]   mem_z [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   credit_sum;

  logic xfer;
  logic capture;
  logic push;
  logic pop;
  logic cfg_ok;

  // Every in-flight sample already owns a FIFO slot, so the FIFO cannot
  // overflow even though the datapath never stalls.
  assign credit_sum = SUM_W'(inflight) + SUM_W'(fifo_count);
  assign s_ready    = !rst && !cfg_we && (credit_sum < SUM_W'(FIFO_DEPTH));
  assign xfer       = s_valid && s_ready;

  assign capture = tag[LATENCY-1];
  assign push    = capture;
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;

  // Coefficients may only change when nothing is in the datapath.
  assign cfg_ok = cfg_we && (inflight == '0) && !dp_vld;

  // Head is gated so stale storage never shows on the outputs.
  assign m_y = m_valid ? mem_y[rd_ptr] : '0;
  assign m_z = m_valid ? mem_z[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vld   <= 1'b0;
      dp_a     <= '0;
      dp_b     <= '0;
      tag      <= '0;
      inflight <= '0;
      cfg_err  <= 1'b0;
      dp_m1    <= M1_RST;
      dp_m2    <= M2_RST;
      dp_m3    <= M3_RST;
      dp_m4    <= M4_RST;
    end else begin
      dp_vld <= xfer;
      if (xfer) begin
        dp_a <= s_a;
        dp_b <= s_b;
      end

      // Tag output lines up with the cycle dp_y/dp_z are valid.
      tag <= {tag[LATENCY-2:0], dp_vld};

      case ({xfer, capture})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase

      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        case (cfg_addr)
          2'd0: dp_m1 <= cfg_data;
          2'd1: dp_m2 <= cfg_data;
          2'd2: dp_m3 <= cfg_data;
          2'd3: dp_m4 <= cfg_data;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_y[wr_ptr] <= dp_y;
      mem_z[wr_ptr] <= dp_z;
    end
  end

  no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
module tb_matrix_stream_ctrl;

  localparam int LATENCY    = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int IN_W       = 13;
  localparam int OUT_W      = 17;
  localparam int COEF_W     = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_addr;
  logic [COEF_W-1:0] cfg_data;
  logic              cfg_err;
  logic              s_valid;
  logic              s_ready;
  logic [IN_W-1:0]   s_a;
  logic [IN_W-1:0]   s_b;
  logic              dp_vld;
  logic [IN_W-1:0]   dp_a;
  logic [IN_W-1:0]   dp_b;
  logic [COEF_W-1:0] dp_m1, dp_m2, dp_m3, dp_m4;
  logic [OUT_W-1:0]  dp_y;
  logic [OUT_W-1:0]  dp_z;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_y;
  logic [OUT_W-1:0]  m_z;
  logic [2:0]        inflight;

  always #5 clk = ~clk;

  matrix_stream_ctrl #(
    .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .dp_vld(dp_vld), .dp_a(dp_a), .dp_b(dp_b),
    .dp_m1(dp_m1), .dp_m2(dp_m2), .dp_m3(dp_m3), .dp_m4(dp_m4),
    .dp_y(dp_y), .dp_z(dp_z),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_z(m_z),
    .inflight(inflight)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Golden datapath arithmetic: signed products, result = sum[30:14].
  function automatic logic [OUT_W-1:0] dp_calc(input logic [COEF_W-1:0] ma, input logic [COEF_W-1:0] mb,
                                               input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    logic signed [32:0] p1, p2, s;
    p1 = 33'($signed(ma)) * 33'($signed(a));
    p2 = 33'($signed(mb)) * 33'($signed(b));
    s  = p1 + p2;
    return s[30:14];
  endfunction

  // Datapath model: LATENCY-stage pipeline, unaffected by controller reset.
  logic [OUT_W-1:0] py [LATENCY];
  logic [OUT_W-1:0] pz [LATENCY];
  always @(posedge clk) begin
    py[0] <= dp_calc(dp_m1, dp_m2, dp_a, dp_b);
    pz[0] <= dp_calc(dp_m3, dp_m4, dp_a, dp_b);
    for (int i = 1; i < LATENCY; i++) begin
      py[i] <= py[i-1];
      pz[i] <= pz[i-1];
    end
  end
  assign dp_y = py[LATENCY-1];
  assign dp_z = pz[LATENCY-1];

  // Scoreboard: expected results queued at handshake, compared at pop.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2*OUT_W-1:0] exp_q [$];
  int pop_cnt   = 0;
  int pop_first = 0;
  int pop_last  = 0;

  always @(negedge clk) begin
    logic [2*OUT_W-1:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected actual=%0h_%0h required=no_output", m_y, m_z);
        end else begin
          e = exp_q.pop_front();
          check("stream_y", 64'(m_y), 64'(e[2*OUT_W-1:OUT_W]));
          check("stream_z", 64'(m_z), 64'(e[OUT_W-1:0]));
        end
        if (pop_cnt == 0) pop_first = cyc;
        pop_last = cyc;
        pop_cnt++;
      end
      if (s_valid && s_ready)
        exp_q.push_back({dp_calc(dp_m1, dp_m2, s_a, s_b), dp_calc(dp_m3, dp_m4, s_a, s_b)});
    end
  end

  typedef struct {
    logic [COEF_W-1:0] m1, m2, m3, m4;
    logic [IN_W-1:0]   a, b;
    logic [OUT_W-1:0]  y, z;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [COEF_W-1:0] data);
    cfg_we   = 1'b1;
    cfg_addr = addr;
    cfg_data = data;
    @(negedge clk);
    check("cfg_blocks_ready", 64'(s_ready), 64'(0));
    tick();
    cfg_we = 1'b0;
  endtask

  // Presents one sample, then measures cycles from handshake to m_valid.
  task automatic send_and_wait(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                               input logic [OUT_W-1:0] ey, input logic [OUT_W-1:0] ez);
    int n;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    @(negedge clk);
    check("single_ready", 64'(s_ready), 64'(1));
    tick();
    s_valid = 1'b0;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (m_valid) break;
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(LATENCY + 2));
    check("single_y", 64'(m_y), 64'(ey));
    check("single_z", 64'(m_z), 64'(ez));
    tick();
  endtask

  task automatic drain(input int target);
    for (int w = 0; w < 100 && pop_cnt < target; w++) tick();
    repeat (10) tick();
    check("drain_count", 64'(pop_cnt), 64'(target));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, stalls, stray;

    vecs[0] = '{19'h04000, 19'h00000, 19'h00000, 19'h04000, 13'd100,  13'h1FFB, 17'h00064, 17'h1FFFB};
    vecs[1] = '{19'h04000, 19'h00000, 19'h00000, 19'h04000, 13'h1000, 13'h0FFF, 17'h1F000, 17'h00FFF};
    vecs[2] = '{19'h02000, 19'h02000, 19'h7C000, 19'h00000, 13'd10,   13'd20,   17'h0000F, 17'h1FFF6};
    vecs[3] = '{19'h7F8F6, 19'h09333, 19'h0C8F6, 19'h53000, 13'd1024, 13'd0,    17'h1FF8F, 17'h00C8F};
    vecs[4] = '{19'h00000, 19'h7FFFF, 19'h00000, 19'h04000, 13'd0,    13'd1,    17'h1FFFF, 17'h00001};
    vecs[5] = '{19'h7F8F6, 19'h09333, 19'h0C8F6, 19'h53000, 13'd0,    13'd64,   17'h00093, 17'h1FD30};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    s_valid = 1'b0; s_a = '0; s_b = '0; m_ready = 1'b0;

    tick();
    tick();
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m1", 64'(dp_m1), 64'(19'h7F8F6));
    check("rst_m2", 64'(dp_m2), 64'(19'h09333));
    check("rst_m3", 64'(dp_m3), 64'(19'h0C8F6));
    check("rst_m4", 64'(dp_m4), 64'(19'h53000));
    check("rst_dp", 64'({dp_vld, dp_a, dp_b}), 64'(0));
    check("rst_cfg_err", 64'(cfg_err), 64'(0));
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_fifo", 64'({m_valid, m_y, m_z}), 64'(0));
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(s_ready), 64'(1));
    tick();

    // Table-driven single-sample vectors.
    for (int v = 0; v < 6; v++) begin
      cfg_write(2'd0, vecs[v].m1);
      cfg_write(2'd1, vecs[v].m2);
      cfg_write(2'd2, vecs[v].m3);
      cfg_write(2'd3, vecs[v].m4);
      @(negedge clk);
      check("vec_coefs", 64'({dp_m1, dp_m2, dp_m3}), 64'({vecs[v].m1, vecs[v].m2, vecs[v].m3}));
      check("vec_coef_m4", 64'(dp_m4), 64'(vecs[v].m4));
      tick();
      send_and_wait(vecs[v].a, vecs[v].b, vecs[v].y, vecs[v].z);
    end

    // Continuous stream, one per cycle.
    pop_cnt = 0;
    k = 0;
    stalls = 0;
    for (int g = 0; g < 200 && k < 64; g++) begin
      s_valid = 1'b1;
      s_a = IN_W'(k);
      s_b = IN_W'(-k);
      @(negedge clk);
      if (s_ready) k++;
      else stalls++;
      tick();
    end
    s_valid = 1'b0;
    check("stream_no_stall", 64'(stalls), 64'(0));
    drain(64);
    check("stream_back_to_back", 64'(pop_last - pop_first), 64'(63));

    // Output backpressure: credits stop acceptance at FIFO_DEPTH.
    m_ready = 1'b0;
    pop_cnt = 0;
    k = 0;
    for (int c = 0; c < 30; c++) begin
      s_valid = 1'b1;
      s_a = IN_W'(200 + k);
      s_b = IN_W'(3 * k - 30);
      @(negedge clk);
      if (s_ready) k++;
      tick();
    end
    @(negedge clk);
    check("bp_accepted", 64'(k), 64'(FIFO_DEPTH));
    check("bp_ready_low", 64'(s_ready), 64'(0));
    check("bp_inflight", 64'(inflight), 64'(0));
    check("bp_m_valid", 64'(m_valid), 64'(1));
    tick();
    m_ready = 1'b1;
    for (int g = 0; g < 100 && k < 20; g++) begin
      s_valid = 1'b1;
      s_a = IN_W'(200 + k);
      s_b = IN_W'(3 * k - 30);
      @(negedge clk);
      if (s_ready) k++;
      tick();
    end
    s_valid = 1'b0;
    drain(20);

    // Coefficient write while busy is rejected.
    cfg_write(2'd0, 19'h04000);
    cfg_write(2'd1, 19'h00000);
    cfg_write(2'd2, 19'h00000);
    cfg_write(2'd3, 19'h04000);
    pop_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_a = IN_W'(7 * i + 1);
      s_b = IN_W'(5 - i);
      tick();
    end
    s_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 19'h01234;
    @(negedge clk);
    check("busy_inflight", 64'(inflight), 64'(3));
    check("busy_ready_low", 64'(s_ready), 64'(0));
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", 64'(cfg_err), 64'(1));
    check("cfg_rejected", 64'(dp_m1), 64'(19'h04000));
    tick();
    @(negedge clk);
    check("cfg_err_one_cycle", 64'(cfg_err), 64'(0));
    tick();
    drain(3);

    // Accepted write with a sample offered in the same cycle.
    s_valid = 1'b1; s_a = 13'd5; s_b = 13'd5;
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 19'h00123;
    @(negedge clk);
    check("cfg_write_blocks", 64'(s_ready), 64'(0));
    tick();
    cfg_we = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check("cfg_write_taken", 64'(dp_m2), 64'(19'h00123));
    check("cfg_write_no_err", 64'(cfg_err), 64'(0));
    check("no_launch_on_write", 64'(dp_vld), 64'(0));
    tick();

    // Reset with 4 in flight and 3 in the FIFO.
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1;
      s_a = IN_W'(300 + i);
      s_b = IN_W'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_inflight", 64'(inflight), 64'(4));
    check("pre_rst_m_valid", 64'(m_valid), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("post_rst_m_valid", 64'(m_valid), 64'(0));
    check("post_rst_inflight", 64'(inflight), 64'(0));
    check("post_rst_head", 64'({m_y, m_z}), 64'(0));
    check("post_rst_coef", 64'(dp_m2), 64'(19'h09333));
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      if (m_valid) stray++;
    end
    check("late_outputs_ignored", 64'(stray), 64'(0));
    tick();
    send_and_wait(13'd1024, 13'd0, 17'h1FF8F, 17'h00C8F);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
